// File: rtl/write_reg_pkg.sv
// Shared constants for the register-file write side and its read muxes.
// Also holds the byte-lane merge used when WREG_BYTE_MASK_EN is defined.
package write_reg_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [DATA_W-1:0] ZERO_WORD = 32'h00000000;

  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [3:0]        be
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int j = 0; j < 4; j++) begin
      if (be[j]) res[8*j +: 8] = new_word[8*j +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/write_reg_dec_n.sv
// Enabled n-to-2^n one-hot decoder: onehot[i] = en & (sel == i).
module dec_n #(
  parameter int N = 5
) (
  input  logic               en,
  input  logic [N-1:0]       sel,
  output logic [(1<<N)-1:0]  onehot
);

  for (genvar i = 0; i < (1 << N); i++) begin : g_dec
    assign onehot[i] = en & (sel == N'(i));
  end

endmodule

// File: rtl/write_reg.sv
// Write side of a 32-entry register file; r0 is hard-wired zero, r1..r31 are flops.
// Optional byte-lane write masking is enabled with the macro WREG_BYTE_MASK_EN (WIDTH must be 32).
module write_reg
  import write_reg_pkg::*;
#(
  parameter int                WIDTH     = DATA_W,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
`ifdef WREG_BYTE_MASK_EN
  input  logic [3:0]            wbe,
`endif
  output logic [WIDTH-1:0]      r0,
  output logic [WIDTH-1:0]      r1,
  output logic [WIDTH-1:0]      r2,
  output logic [WIDTH-1:0]      r3,
  output logic [WIDTH-1:0]      r4,
  output logic [WIDTH-1:0]      r5,
  output logic [WIDTH-1:0]      r6,
  output logic [WIDTH-1:0]      r7,
  output logic [WIDTH-1:0]      r8,
  output logic [WIDTH-1:0]      r9,
  output logic [WIDTH-1:0]      r10,
  output logic [WIDTH-1:0]      r11,
  output logic [WIDTH-1:0]      r12,
  output logic [WIDTH-1:0]      r13,
  output logic [WIDTH-1:0]      r14,
  output logic [WIDTH-1:0]      r15,
  output logic [WIDTH-1:0]      r16,
  output logic [WIDTH-1:0]      r17,
  output logic [WIDTH-1:0]      r18,
  output logic [WIDTH-1:0]      r19,
  output logic [WIDTH-1:0]      r20,
  output logic [WIDTH-1:0]      r21,
  output logic [WIDTH-1:0]      r22,
  output logic [WIDTH-1:0]      r23,
  output logic [WIDTH-1:0]      r24,
  output logic [WIDTH-1:0]      r25,
  output logic [WIDTH-1:0]      r26,
  output logic [WIDTH-1:0]      r27,
  output logic [WIDTH-1:0]      r28,
  output logic [WIDTH-1:0]      r29,
  output logic [WIDTH-1:0]      r30,
  output logic [WIDTH-1:0]      r31
);

  logic [NUM_REGS-1:0] strobe;
  logic [WIDTH-1:0]    regs [1:NUM_REGS-1];
  logic                strobe0_unused;

  dec_n #(.N(REG_ADDR_W)) u_dec (
    .en     (we),
    .sel    (waddr),
    .onehot (strobe)
  );

  // r0 has no storage, so its strobe is deliberately dropped.
  assign strobe0_unused = strobe[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (strobe[i]) begin
`ifdef WREG_BYTE_MASK_EN
          regs[i] <= byte_merge(regs[i], wdata, wbe);
`else
          regs[i] <= wdata;
`endif
        end
      end
    end
  end

  assign r0  = WIDTH'(ZERO_WORD);
  assign r1  = regs[1];
  assign r2  = regs[2];
  assign r3  = regs[3];
  assign r4  = regs[4];
  assign r5  = regs[5];
  assign r6  = regs[6];
  assign r7  = regs[7];
  assign r8  = regs[8];
  assign r9  = regs[9];
  assign r10 = regs[10];
  assign r11 = regs[11];
  assign r12 = regs[12];
  assign r13 = regs[13];
  assign r14 = regs[14];
  assign r15 = regs[15];
  assign r16 = regs[16];
  assign r17 = regs[17];
  assign r18 = regs[18];
  assign r19 = regs[19];
  assign r20 = regs[20];
  assign r21 = regs[21];
  assign r22 = regs[22];
  assign r23 = regs[23];
  assign r24 = regs[24];
  assign r25 = regs[25];
  assign r26 = regs[26];
  assign r27 = regs[27];
  assign r28 = regs[28];
  assign r29 = regs[29];
  assign r30 = regs[30];
  assign r31 = regs[31];

endmodule

// File: tb/tb_write_reg.sv
// Scoreboard bench for write_reg: stimulus pushes full expected register snapshots,
// a negedge monitor pops them and compares all 32 outputs.
module tb_write_reg;

  localparam logic [31:0] RV = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
`ifdef WREG_BYTE_MASK_EN
  logic [3:0]  wbe = 4'hF;
`endif
  logic [31:0] r [32];

  typedef struct { logic [31:0] v [32]; } snap_t;
  snap_t       sbq [$];
  logic [31:0] exp_r [32];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  write_reg #(.WIDTH(32), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
`ifdef WREG_BYTE_MASK_EN
    .wbe(wbe),
`endif
    .r0(r[0]),   .r1(r[1]),   .r2(r[2]),   .r3(r[3]),
    .r4(r[4]),   .r5(r[5]),   .r6(r[6]),   .r7(r[7]),
    .r8(r[8]),   .r9(r[9]),   .r10(r[10]), .r11(r[11]),
    .r12(r[12]), .r13(r[13]), .r14(r[14]), .r15(r[15]),
    .r16(r[16]), .r17(r[17]), .r18(r[18]), .r19(r[19]),
    .r20(r[20]), .r21(r[21]), .r22(r[22]), .r23(r[23]),
    .r24(r[24]), .r25(r[25]), .r26(r[26]), .r27(r[27]),
    .r28(r[28]), .r29(r[29]), .r30(r[30]), .r31(r[31])
  );

  // One clock of stimulus; the model follows the register-file rules directly.
  task automatic step(input logic s_rst, input logic s_we, input logic [4:0] s_addr,
                      input logic [31:0] s_data, input logic [3:0] s_be, input bit chk);
    snap_t s;
    @(negedge clk);
    rst = s_rst; we = s_we; waddr = s_addr; wdata = s_data;
`ifdef WREG_BYTE_MASK_EN
    wbe = s_be;
`endif
    @(posedge clk);
    #1;
    if (s_rst) begin
      for (int i = 1; i < 32; i++) exp_r[i] = RV;
    end else if (s_we && s_addr != 5'd0) begin
      for (int j = 0; j < 4; j++)
        if (s_be[j]) exp_r[s_addr][8*j +: 8] = s_data[8*j +: 8];
    end
    exp_r[0] = 32'h0;
    if (chk) begin
      for (int i = 0; i < 32; i++) s.v[i] = exp_r[i];
      sbq.push_back(s);
    end
  endtask

  initial begin : monitor
    snap_t s;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        s = sbq.pop_front();
        for (int i = 0; i < 32; i++) begin
          checks++;
          if (r[i] !== s.v[i]) begin
            failures++;
            $display("FAIL reg_r%0d at %0t: got %h expected %h", i, $time, r[i], s.v[i]);
          end
        end
      end
    end
  end

  initial begin : stim
    int waited;
    for (int i = 0; i < 32; i++) exp_r[i] = 'x;

    // Reset with some write traffic first, then reset alone.
    step(1'b0, 1'b1, 5'd9, 32'h55555555, 4'hF, 1'b0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 4'hF, 1'b1);

    // Single write, then a discarded write to r0.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b1);
    step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b1);

    // Walk i+100 into ri on consecutive cycles, then idle with random addr/data.
    for (int i = 1; i < 32; i++) step(1'b0, 1'b1, 5'(i), 32'(i + 100), 4'hF, 1'b0);
    for (int k = 0; k < 10; k++)
      step(1'b0, 1'b0, 5'($urandom_range(31, 0)), $urandom, 4'hF, (k == 9));

    // Reset beats a simultaneous write.
    step(1'b0, 1'b1, 5'd7, 32'h12345678, 4'hF, 1'b1);
    step(1'b1, 1'b1, 5'd7, 32'hAAAAAAAA, 4'hF, 1'b1);

    // Reset mid-sequence drops its write; next write behaves normally.
    step(1'b0, 1'b1, 5'd2, 32'h00000002, 4'hF, 1'b0);
    step(1'b0, 1'b1, 5'd3, 32'h00000003, 4'hF, 1'b1);
    step(1'b1, 1'b1, 5'd4, 32'h00000004, 4'hF, 1'b1);
    step(1'b0, 1'b1, 5'd4, 32'hCAFEF00D, 4'hF, 1'b1);

    // Back-to-back same index keeps the last value; full-width pattern on r31.
    step(1'b0, 1'b1, 5'd9, 32'h00000001, 4'hF, 1'b0);
    step(1'b0, 1'b1, 5'd9, 32'h00000002, 4'hF, 1'b1);
    step(1'b0, 1'b1, 5'd31, 32'h80000001, 4'hF, 1'b1);
    step(1'b0, 1'b1, 5'd30, 32'hFFFFFFFF, 4'hF, 1'b1);

`ifdef WREG_BYTE_MASK_EN
    step(1'b0, 1'b1, 5'd3, 32'h11223344, 4'hF, 1'b1);
    step(1'b0, 1'b1, 5'd3, 32'hAABBCCDD, 4'b0101, 1'b1);
    step(1'b0, 1'b1, 5'd3, 32'h99999999, 4'b0000, 1'b1);
    step(1'b0, 1'b1, 5'd3, 32'h77665544, 4'b1010, 1'b1);
`endif

    step(1'b0, 1'b0, 5'd0, 32'h0, 4'hF, 1'b1);

    waited = 0;
    while (sbq.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d snapshots left, expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/write_reg.md
WRITE_REG -- requirements
Module: write_reg

Interface
REQ-001 Parameter: WIDTH, default 32, data width of every register, wdata and r0..r31.
REQ-002 Parameter: RESET_VAL, default 32'h00000000, value loaded into r1..r31 on reset.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: we  input  1  write enable for the current cycle.
REQ-006 Port: waddr  input  5  destination register index, 0..31.
REQ-007 Port: wdata  input  WIDTH  data to be written.
REQ-008 Port: wbe  input  4  byte-write mask; present only when WREG_BYTE_MASK_EN is defined.
REQ-009 Ports: r0..r31  output  WIDTH each  current register contents; these feed the register-file read muxes directly.

Function
REQ-010 The block SHALL hold 31 storage registers, r1..r31.
REQ-011 r0 SHALL be constant zero: there is no storage behind it, and writes to it are discarded.
REQ-012 waddr SHALL be decoded one-hot into 32 write strobes (strobe[i] = we & (waddr==i)).
REQ-013 On a rising clk edge with rst=0, we=1 and waddr=k, where k is 1..31, register rk SHALL load wdata.
REQ-014 Latency: the new value SHALL appear on rk in the cycle after the write edge, with no combinational path from wdata to any rN.
REQ-015 All registers not addressed, and all registers when we=0, SHALL hold their value.
REQ-016 When we=0, waddr and wdata values (including X) SHALL have no effect on any output.
REQ-017 A write with waddr=0 SHALL leave r0=0 and all of r1..r31 unchanged.
REQ-018 Back-to-back writes to the same index on consecutive cycles SHALL leave the last value written.
REQ-019 Writes to different indices on consecutive cycles SHALL each take effect independently.
REQ-020 Width rule: wdata SHALL be stored bit-for-bit; no sign extension or truncation.

Reset
REQ-021 When rst=1 at a rising edge, r1..r31 SHALL load RESET_VAL, and r0 SHALL remain 0.
REQ-022 Reset SHALL take priority over a simultaneous write: with rst=1 and we=1, the written register still takes RESET_VAL.
REQ-023 Reset asserted mid-sequence SHALL discard that cycle's write; the first write after rst deasserts SHALL behave normally.
REQ-024 Outputs SHALL be undefined only before the first reset edge.

Configuration
REQ-025 Macro WREG_BYTE_MASK_EN SHALL control byte masking.
REQ-026 With WREG_BYTE_MASK_EN defined, port wbe SHALL exist, and a write SHALL update byte j of rk only where wbe[j]=1; bytes with wbe[j]=0 hold their value, and wbe=4'b0000 behaves as no write. This mode requires WIDTH=32.
REQ-027 Without WREG_BYTE_MASK_EN, there SHALL be no wbe port, and every write SHALL update all WIDTH bits.

Structure
REQ-028 The shared package SHALL hold NUM_REGS=32, REG_ADDR_W=5, DATA_W=32 and ZERO_WORD=32'h00000000; both the read and write sides use these constants.
REQ-029 The write decoder SHALL be an instance of the existing decoder sub-module dec_n with n=5, and no other sub-module is required.

Verification
REQ-030 Reset: rst=1 for one edge with RESET_VAL=0 -> all r0..r31 read 32'h00000000 on the next cycle.
REQ-031 Single write: we=1, waddr=5, wdata=32'hDEADBEEF for one edge -> r5=32'hDEADBEEF on the next cycle, every other rN unchanged.
REQ-032 r0 write: we=1, waddr=0, wdata=32'hFFFFFFFF -> r0 stays 32'h00000000, and r1..r31 are unchanged.
REQ-033 Walk: write value i+100 to ri for i=1..31 on consecutive cycles, then hold we=0 with random waddr/wdata for 10 cycles -> every ri equals i+100.
REQ-034 Reset priority: r7=32'h12345678, then rst=1 together with we=1, waddr=7, wdata=32'hAAAAAAAA -> r7=RESET_VAL.
REQ-035 Byte mask (WREG_BYTE_MASK_EN): r3=32'h11223344, then a write with wbe=4'b0101 and wdata=32'hAABBCCDD -> r3=32'h11BB33DD.
